// File: rtl/bzmusic_player_dp_if.sv
// -----------------------------------------------------------------------------
// bzmusic_player_dp_if
// Strobe/status bundle between the buzzer-music sequencing controller and its
// datapath.
//   addr_en        fetch strobe: capture current ROM word, advance address
//   addr_rstn      synchronous active-low clear of the address counter
//   tune_pwm_en    tone generator run enable
//   tune_pwm_rstn  synchronous active-low clear of the tone generator
//   beat_cnt_en    beat timer run enable
//   beat_cnt_rstn  synchronous active-low clear of the beat timer
//   addr_finish    song consumed (address counter reached the song length)
//   beat_finish    single-cycle end-of-note pulse
// The controller side uses the master modport, the datapath the slave modport.
// -----------------------------------------------------------------------------
interface bzmusic_player_dp_if;
  logic addr_en;
  logic addr_rstn;
  logic tune_pwm_en;
  logic tune_pwm_rstn;
  logic beat_cnt_en;
  logic beat_cnt_rstn;
  logic addr_finish;
  logic beat_finish;

  modport master (
    output addr_en, addr_rstn,
    output tune_pwm_en, tune_pwm_rstn,
    output beat_cnt_en, beat_cnt_rstn,
    input  addr_finish, beat_finish
  );

  modport slave (
    input  addr_en, addr_rstn,
    input  tune_pwm_en, tune_pwm_rstn,
    input  beat_cnt_en, beat_cnt_rstn,
    output addr_finish, beat_finish
  );
endinterface

// File: rtl/bzmusic_player_dp.sv
// -----------------------------------------------------------------------------
// bzmusic_player_dp
// Datapath behind the buzzer-music sequencing controller. It walks an
// asynchronous-read song ROM, holds the current note word, times the note
// length in duration units and generates the square-wave buzzer output.
//
// Ports:
//   clk       system clock
//   rstn      asynchronous active-low reset
//   ctrl      controller strobes in, addr_finish / beat_finish out (slave)
//   rom_data  note word: [7:6] octave, [5:3] note (0 = rest), [2:0] duration
//   rom_addr  song ROM address (equals the address counter)
//   buzz      buzzer square wave
// -----------------------------------------------------------------------------
module bzmusic_player_dp #(
  parameter int ADDR_W    = 8,
  parameter int SONG_LEN  = 64,
  parameter int BEAT_UNIT = 3125000
) (
  input  logic              clk,
  input  logic              rstn,
  bzmusic_player_dp_if.slave ctrl,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              buzz
);

  localparam int TICK_W = (BEAT_UNIT > 1) ? $clog2(BEAT_UNIT) : 1;
  localparam logic [ADDR_W-1:0] SONG_END  = ADDR_W'(SONG_LEN);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_UNIT - 1);

  typedef struct packed {
    logic [1:0] oct;
    logic [2:0] note;
    logic [2:0] dur;
  } note_word_t;

  // Half period in clk cycles for a note at the given octave.
  // Table entries are the mid-octave values at 50 MHz; octave 0 is one octave
  // down, octave 2 one octave up, octaves 1 and 3 both play mid.
  function automatic logic [17:0] half_period(input logic [2:0] note,
                                              input logic [1:0] oct);
    logic [17:0] h;
    h = '0;
    case (note)
      3'd1:    h = 18'd95420;
      3'd2:    h = 18'd85034;
      3'd3:    h = 18'd75758;
      3'd4:    h = 18'd71633;
      3'd5:    h = 18'd63776;
      3'd6:    h = 18'd56818;
      3'd7:    h = 18'd50607;
      default: h = '0;
    endcase
    case (oct)
      2'd0:    return h << 1;
      2'd2:    return h >> 1;
      default: return h;
    endcase
  endfunction

  logic [ADDR_W-1:0] addr_cnt;
  note_word_t        word_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        unit_cnt;
  logic [17:0]       div_cnt;
  logic [17:0]       div_last;
  logic              addr_finish;
  logic              fetch;
  logic              tick_wrap;

  // ---------------------------------------------------------------------------
  // Address block: the counter saturates at SONG_LEN, so strobes after the end
  // of the song neither advance the address nor overwrite the held note.
  // The synchronous clear beats the fetch strobe in the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: combinational outputs are pure continuous assignments, so no path
  // can leave a signal unassigned and infer a latch.
  assign addr_finish = (addr_cnt == SONG_END);
  assign fetch       = ctrl.addr_rstn & ctrl.addr_en & ~addr_finish;
  assign rom_addr    = addr_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_cnt <= '0;
    end else if (!ctrl.addr_rstn) begin
      addr_cnt <= '0;
    end else if (fetch) begin
      addr_cnt <= addr_cnt + 1'b1;
    end
  end

  // The note word is reset too: the tone generator treats note 0 as a rest,
  // so after reset the buzzer stays silent until a real word is fetched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= '0;
    end else if (fetch) begin
      word_q <= note_word_t'(rom_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat timer: tick_cnt divides clk down to duration units, unit_cnt counts
  // units. The note ends in the last tick of unit dur, giving exactly
  // (dur+1)*BEAT_UNIT enabled cycles. unit_cnt is free-running 3 bits.
  // ---------------------------------------------------------------------------
  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
    end else if (!ctrl.beat_cnt_rstn) begin
      tick_cnt <= '0;
      unit_cnt <= '0;
    end else if (ctrl.beat_cnt_en) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        unit_cnt <= unit_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign ctrl.beat_finish = ctrl.beat_cnt_en & tick_wrap & (unit_cnt == word_q.dur);
  assign ctrl.addr_finish = addr_finish;

  // ---------------------------------------------------------------------------
  // Tone generator: div_cnt counts 0..H-1 and the output toggles on the last
  // count, so the first edge lands H enabled cycles after the run starts.
  // A rest forces the generator idle; a dropped enable freezes it in place.
  // ---------------------------------------------------------------------------
  assign div_last = half_period(word_q.note, word_q.oct) - 18'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      buzz    <= 1'b0;
    end else if (!ctrl.tune_pwm_rstn || word_q.note == 3'd0) begin
      div_cnt <= '0;
      buzz    <= 1'b0;
    end else if (ctrl.tune_pwm_en) begin
      if (div_cnt == div_last) begin
        div_cnt <= '0;
        buzz    <= ~buzz;
      end else begin
        div_cnt <= div_cnt + 18'd1;
      end
    end
  end

endmodule

// File: tb/tb_bzmusic_player_dp.sv
// -----------------------------------------------------------------------------
// tb_bzmusic_player_dp
// Directed bench for bzmusic_player_dp with SONG_LEN=3 and BEAT_UNIT=4. The
// song ROM is an array read combinationally by rom_addr. Expected values are
// hand-derived from the note-word encoding and the cycle rules of the block.
// -----------------------------------------------------------------------------
module tb_bzmusic_player_dp;

  localparam int ADDR_W    = 8;
  localparam int SONG_LEN  = 3;
  localparam int BEAT_UNIT = 4;

  logic              clk;
  logic              rstn;
  logic [7:0]        rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              buzz;
  logic [7:0]        rom [0:255];

  int errors = 0;
  int checks = 0;

  bzmusic_player_dp_if bus ();

  bzmusic_player_dp #(
    .ADDR_W    (ADDR_W),
    .SONG_LEN  (SONG_LEN),
    .BEAT_UNIT (BEAT_UNIT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ctrl     (bus),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .buzz     (buzz)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Controller fetch state: capture word, clear tone and beat timer.
  task automatic fetch();
    bus.addr_en       = 1'b1;
    bus.tune_pwm_rstn = 1'b0;
    bus.beat_cnt_rstn = 1'b0;
    bus.tune_pwm_en   = 1'b0;
    bus.beat_cnt_en   = 1'b0;
    cycle(1);
    bus.addr_en       = 1'b0;
    bus.tune_pwm_rstn = 1'b1;
    bus.beat_cnt_rstn = 1'b1;
  endtask

  // Controller play state for len cycles; beat_finish must pulse only in the
  // last one, and the buzzer must stay low while the note is too short to
  // reach its first edge.
  task automatic play(input string tag, input int len);
    bus.beat_cnt_en = 1'b1;
    bus.tune_pwm_en = 1'b1;
    for (int i = 1; i <= len; i++) begin
      check({tag, "_beat_finish"}, 32'(bus.beat_finish), 32'(i == len));
      check({tag, "_buzz"}, 32'(buzz), 32'd0);
      cycle(1);
    end
    bus.beat_cnt_en = 1'b0;
    bus.tune_pwm_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'b01_110_001;  // mid la, two units
    rom[1] = 8'b01_000_000;  // rest, one unit
    rom[2] = 8'b10_111_000;  // high ti, one unit: H = 50607>>1 = 25303
    rom[3] = 8'b01_001_011;  // beyond the song; must never be captured

    bus.addr_en       = 1'b0;
    bus.addr_rstn     = 1'b1;
    bus.tune_pwm_en   = 1'b0;
    bus.tune_pwm_rstn = 1'b1;
    bus.beat_cnt_en   = 1'b0;
    bus.beat_cnt_rstn = 1'b1;
    rstn              = 1'b0;

    // Reset state
    #3;
    check("rst_rom_addr",    32'(rom_addr),        32'd0);
    check("rst_addr_finish", 32'(bus.addr_finish), 32'd0);
    check("rst_beat_finish", 32'(bus.beat_finish), 32'd0);
    check("rst_buzz",        32'(buzz),            32'd0);
    @(negedge clk);
    rstn = 1'b1;
    cycle(1);

    // Fetch word 0 and play it: (1+1)*4 = 8 cycles
    fetch();
    check("fetch0_rom_addr",    32'(rom_addr),        32'd1);
    check("fetch0_addr_finish", 32'(bus.addr_finish), 32'd0);
    play("note0", 8);

    // Rest word: (0+1)*4 = 4 cycles, silent
    fetch();
    check("fetch1_rom_addr", 32'(rom_addr), 32'd2);
    play("rest", 4);

    // High ti: first buzz edge after 25303 enabled cycles
    fetch();
    check("fetch2_rom_addr",    32'(rom_addr),        32'd3);
    check("fetch2_addr_finish", 32'(bus.addr_finish), 32'd1);
    bus.tune_pwm_en = 1'b1;
    cycle(25302);
    check("tone_before_edge1", 32'(buzz), 32'd0);
    cycle(1);
    check("tone_edge1", 32'(buzz), 32'd1);
    bus.tune_pwm_en = 1'b0;
    cycle(10);
    check("tone_frozen", 32'(buzz), 32'd1);
    bus.tune_pwm_en = 1'b1;
    cycle(25302);
    check("tone_before_edge2", 32'(buzz), 32'd1);
    cycle(1);
    check("tone_edge2", 32'(buzz), 32'd0);
    bus.tune_pwm_en = 1'b0;

    // Extra fetch past the end: address and held word must not change
    bus.addr_en       = 1'b1;
    bus.beat_cnt_rstn = 1'b0;
    cycle(1);
    bus.addr_en       = 1'b0;
    bus.beat_cnt_rstn = 1'b1;
    check("sat_rom_addr",    32'(rom_addr),        32'd3);
    check("sat_addr_finish", 32'(bus.addr_finish), 32'd1);
    // Held duration is still 0, so the note ends in its 4th cycle
    bus.beat_cnt_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check("sat_beat_early", 32'(bus.beat_finish), 32'd0);
      cycle(1);
    end
    check("sat_beat_end", 32'(bus.beat_finish), 32'd1);

    // Asynchronous reset mid-note
    #2;
    rstn = 1'b0;
    #1;
    check("arst_rom_addr",    32'(rom_addr),        32'd0);
    check("arst_addr_finish", 32'(bus.addr_finish), 32'd0);
    check("arst_beat_finish", 32'(bus.beat_finish), 32'd0);
    check("arst_buzz",        32'(buzz),            32'd0);
    #1;
    rstn = 1'b1;
    bus.beat_cnt_en = 1'b0;
    cycle(1);
    check("arst_rom_addr_hold", 32'(rom_addr), 32'd0);

    // Low octave ti: H = 50607<<1, so no edge where the high octave had one
    rom[0] = 8'b00_111_000;
    fetch();
    check("low_rom_addr", 32'(rom_addr), 32'd1);
    bus.tune_pwm_en = 1'b1;
    cycle(25303);
    check("low_no_edge_at_high_h", 32'(buzz), 32'd0);
    cycle(25304);
    check("low_no_edge_at_mid_h", 32'(buzz), 32'd0);
    bus.tune_pwm_en = 1'b0;

    // Finish the song, then clear the address counter
    fetch();
    fetch();
    check("end_rom_addr",    32'(rom_addr),        32'd3);
    check("end_addr_finish", 32'(bus.addr_finish), 32'd1);
    bus.addr_rstn = 1'b0;
    cycle(1);
    check("clr_rom_addr",    32'(rom_addr),        32'd0);
    check("clr_addr_finish", 32'(bus.addr_finish), 32'd0);

    // Clear priority: strobes with their clears held must do nothing
    rom[0] = 8'b01_001_011;
    bus.addr_en       = 1'b1;
    bus.beat_cnt_en   = 1'b1;
    bus.beat_cnt_rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("prio_beat_finish", 32'(bus.beat_finish), 32'd0);
      cycle(1);
      check("prio_rom_addr", 32'(rom_addr), 32'd0);
    end
    bus.addr_en       = 1'b0;
    bus.addr_rstn     = 1'b1;
    bus.beat_cnt_rstn = 1'b1;
    // Counters start from 0 and the held duration is still 0 (word 2)
    for (int i = 1; i <= 4; i++) begin
      check("prio_release_beat", 32'(bus.beat_finish), 32'(i == 4));
      cycle(1);
    end
    bus.beat_cnt_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bzmusic_player_dp.md
Name: bzmusic_player_dp

Overview:
Datapath responder to the buzzer-music sequencing controller. It consumes the controller's enable and clear strobes (addr_*, tune_pwm_*, beat_cnt_*). It returns addr_finish and beat_finish. It fetches note words from an asynchronous-read song ROM and drives the square-wave buzzer output. It sits between the controller, the song ROM and the buzzer pin.

Parameters:
ADDR_W, 8, song ROM address width
SONG_LEN, 64, number of note words in the song (1..2^ADDR_W-1)
BEAT_UNIT, 3125000, clk cycles per duration unit (1/16 s at 50 MHz)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
addr_en  input  1  fetch strobe: capture current ROM word, advance address
addr_rstn  input  1  synchronous active-low clear of address counter
tune_pwm_en  input  1  tone generator run enable
tune_pwm_rstn  input  1  synchronous active-low clear of tone generator
beat_cnt_en  input  1  beat timer run enable
beat_cnt_rstn  input  1  synchronous active-low clear of beat timer
rom_data  input  8  note word: [7:6] octave, [5:3] note, [2:0] dur
rom_addr  output  ADDR_W  ROM address (= addr_cnt)
addr_finish  output  1  song consumed
beat_finish  output  1  single-cycle end-of-note pulse
buzz  output  1  buzzer square wave

Behaviour:
- Async reset (rstn=0): addr_cnt=0, note_reg=0, oct_reg=0, dur_reg=0, tick_cnt=0, unit_cnt=0, div_cnt=0, buzz=0. Outputs follow: rom_addr=0, addr_finish=0, beat_finish=0. Reset mid-note aborts silently.
- Each sync clear has priority over its enable in the same cycle.
- Address block:
  - addr_rstn=0 -> addr_cnt<=0.
  - addr_en=1 with addr_cnt<SONG_LEN -> {oct_reg,note_reg,dur_reg}<=rom_data and addr_cnt<=addr_cnt+1.
  - addr_finish = (addr_cnt==SONG_LEN), combinational.
  - addr_en while addr_finish=1 -> no capture, no increment. The count saturates.
- Beat timer, active when beat_cnt_en=1:
  - tick_cnt counts 0..BEAT_UNIT-1 and wraps.
  - On wrap, unit_cnt increments.
  - beat_finish = beat_cnt_en & (tick_cnt==BEAT_UNIT-1) & (unit_cnt==dur_reg), combinational.
  - Note length is exactly (dur_reg+1)*BEAT_UNIT enabled cycles.
  - beat_cnt_rstn=0 -> tick_cnt<=0, unit_cnt<=0.
  - If enable stays high after beat_finish, counters keep running; unit_cnt is 3 bits and wraps.
- Tone generator:
  - Half-period H from note_reg (50 MHz mid octave): 1=95420, 2=85034, 3=75758, 4=71633, 5=63776, 6=56818, 7=50607.
  - oct_reg 0 -> H<<1; 1 or 3 -> H; 2 -> H>>1. Use an 18-bit div_cnt.
  - tune_pwm_rstn=0 -> div_cnt<=0, buzz<=0.
  - tune_pwm_en=1 and note_reg!=0: div_cnt increments. At div_cnt==H-1: div_cnt<=0, buzz<=~buzz. The first edge comes H cycles after enable.
  - note_reg==0 (rest): div_cnt held 0, buzz held 0.
  - tune_pwm_en=0 with rstn high: div_cnt and buzz freeze.
- Per-note sequence (controller S1 then S2):
  - Fetch cycle: addr_en=1, tone and beat clears asserted. Word captured at end of cycle.
  - Play cycles: enables=1. beat_finish pulses in the last cycle.
  - Controller returns to fetch; the clears reset timer and tone.
- Idle (controller S0): addr_rstn=0, so the next song restarts at address 0.
- Simultaneous addr_en and addr_rstn=0: clear wins, no capture.

Test Plan:
- Reset: SONG_LEN=3, BEAT_UNIT=4. Pulse rstn low mid-play -> buzz=0, rom_addr=0, addr_finish=0, beat_finish=0 immediately (async).
- Fetch: ROM[0]=8'b01_110_001 (mid la, dur 1), one addr_en cycle -> rom_addr 0->1, note_reg=6, dur_reg=1. Hold all enables -> beat_finish pulses exactly once, on the 8th enabled cycle.
- Tone: BEAT_UNIT large, note 1 octave 2 -> buzz first toggles 47710 cycles after tune_pwm_en rises, then every 47710 cycles. Octave 0 -> period doubles to 190840 per toggle.
- Rest: ROM word note=0, dur=0 played 4 cycles -> buzz stays 0, beat_finish pulses on cycle 4.
- End of song: three fetch/play rounds -> addr_finish=1 at rom_addr=3. Extra addr_en -> rom_addr stays 3, note_reg unchanged. addr_rstn=0 -> rom_addr=0, addr_finish=0.
- Clear priority: assert addr_en with addr_rstn=0, and beat_cnt_en with beat_cnt_rstn=0 -> no increment, counters remain 0, beat_finish stays 0.
